bridge_rx: RTL and testbench

- Upstream head of the register-bus daisy chain; sits between the UART byte receiver and the first memory/IO stage.
- Parses ASCII command frames into single-cycle bus transactions on the standard 16-bit chain interface (addr, wdata, rdata, rw, valid).
- Read frame: 'R' + 4 hex chars + terminator. Write frame: 'W' + 4 hex addr chars + 4 hex data chars + terminator.
- Malformed frames are dropped and flagged.

---
 rtl/bridge_pkg.sv | 31 +++
 rtl/bridge_rx.sv | 133 +++++++++++++
 tb/tb_bridge_rx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII register-bus bridge: character codes,
// parser states and the hex-character decoder.
package bridge_pkg;

  localparam logic [7:0] CHAR_R  = 8'h52;
  localparam logic [7:0] CHAR_W  = 8'h57;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    EOL  = 2'd3
  } state_t;

  // Returns {is_hex, nibble}; nibble is 0 when the byte is not a hex digit.
  function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  function automatic logic is_terminator(input logic [7:0] c);
    return (c == CHAR_CR) || (c == CHAR_LF);
  endfunction

endpackage

// File: rtl/bridge_rx.sv
// Receive side of the ASCII bridge: turns "R<addr>\r" / "W<addr><data>\r"
// frames into single-cycle chain transactions; malformed frames pulse error_o.
module bridge_rx
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            data_i,
  input  logic                  valid_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  output logic                  error_o,
  output logic [1:0]            dbg_state_o
);

  localparam int ANIB = ADDR_WIDTH / 4;
  localparam int DNIB = DATA_WIDTH / 4;
  localparam int MAXN = (ANIB > DNIB) ? ANIB : DNIB;
  localparam int CW   = $clog2(MAXN + 1);

  // Handshake: a byte is consumed on every rising edge where valid_i is high;
  // there is no back-pressure. valid_o/error_o are single-cycle strobes.
  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic                  r_rw_pend;
  logic [ADDR_WIDTH-1:0] r_addr_sh;
  logic [DATA_WIDTH-1:0] r_data_sh;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_rw;
  logic                  r_valid;
  logic                  r_error;

  logic [4:0] w_hex;
  logic       w_is_hex;
  logic [3:0] w_nib;
  logic       w_is_term;

  always_comb begin
    w_hex     = hex_to_nibble(data_i);
    w_is_hex  = w_hex[4];
    w_nib     = w_hex[3:0];
    w_is_term = is_terminator(data_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rw_pend <= 1'b0;
      r_addr_sh <= '0;
      r_data_sh <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rw      <= 1'b0;
      r_valid   <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      if (valid_i) begin
        case (r_state)
          IDLE: begin
            // Anything but a frame start (including a stray LF) is dropped silently.
            if (data_i == CHAR_R || data_i == CHAR_W) begin
              r_cnt     <= '0;
              r_rw_pend <= (data_i == CHAR_W);
              r_addr_sh <= '0;
              r_data_sh <= '0;
              r_state   <= ADDR;
            end
          end
          ADDR: begin
            if (w_is_hex) begin
              r_addr_sh <= (r_addr_sh << 4) | ADDR_WIDTH'(w_nib);
              if (r_cnt == CW'(ANIB - 1)) begin
                r_cnt   <= '0;
                r_state <= r_rw_pend ? DATA : EOL;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_error <= 1'b1;
              r_state <= IDLE;
            end
          end
          DATA: begin
            if (w_is_hex) begin
              r_data_sh <= (r_data_sh << 4) | DATA_WIDTH'(w_nib);
              if (r_cnt == CW'(DNIB - 1)) begin
                r_cnt   <= '0;
                r_state <= EOL;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end else begin
              r_error <= 1'b1;
              r_state <= IDLE;
            end
          end
          EOL: begin
            // Bus outputs only move here, so partial frames never reach the chain.
            if (w_is_term) begin
              r_addr  <= r_addr_sh;
              r_wdata <= r_rw_pend ? r_data_sh : '0;
              r_rw    <= r_rw_pend;
              r_valid <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign rdata_o     = '0;
  assign rw_o        = r_rw;
  assign valid_o     = r_valid;
  assign error_o     = r_error;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bridge_rx.sv
// Self-checking bench for bridge_rx: directed frames from the test plan plus
// randomized frames, compared cycle by cycle against a frame-buffer model.
module tb_bridge_rx;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int AN = AW / 4;
  localparam int DN = DW / 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    data_i = 8'h00;
  logic          valid_i = 1'b0;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] wdata_o;
  logic [DW-1:0] rdata_o;
  logic          rw_o;
  logic          valid_o;
  logic          error_o;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  bridge_rx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .addr_o      (addr_o),
    .wdata_o     (wdata_o),
    .rdata_o     (rdata_o),
    .rw_o        (rw_o),
    .valid_o     (valid_o),
    .error_o     (error_o),
    .dbg_state_o (dbg_state)
  );

  // ---------------- reference model ----------------
  int n_vec = 0;
  int n_err = 0;
  int n_strobe = 0;
  int n_epulse = 0;

  logic [7:0]    fb[$];
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  logic          exp_rw = 1'b0;
  logic          exp_valid = 1'b0;
  logic          exp_error = 1'b0;
  logic [AW+DW:0] exp_q[$];

  function automatic int hexval(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic model_clear();
    fb.delete();
    exp_addr  = '0;
    exp_wdata = '0;
    exp_rw    = 1'b0;
    exp_valid = 1'b0;
    exp_error = 1'b0;
  endtask

  // Frame buffer model: collects a whole frame, judges each byte by its position.
  task automatic model_byte(input logic [7:0] b);
    int need;
    int a;
    int d;
    bit is_w;
    if (fb.size() == 0) begin
      if (b == 8'h52 || b == 8'h57) fb.push_back(b);
    end else begin
      is_w = (fb[0] == 8'h57);
      need = is_w ? (2 + AN + DN) : (2 + AN);
      if (fb.size() == need - 1) begin
        if (b == 8'h0D || b == 8'h0A) begin
          a = 0;
          d = 0;
          for (int i = 1; i <= AN; i++) a = a * 16 + hexval(fb[i]);
          if (is_w) for (int i = AN + 1; i <= AN + DN; i++) d = d * 16 + hexval(fb[i]);
          exp_addr  = AW'(a);
          exp_wdata = DW'(d);
          exp_rw    = is_w;
          exp_valid = 1'b1;
          exp_q.push_back({is_w, AW'(a), DW'(d)});
        end else begin
          exp_error = 1'b1;
        end
        fb.delete();
      end else if (hexval(b) < 0) begin
        exp_error = 1'b1;
        fb.delete();
      end else begin
        fb.push_back(b);
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] b);
    @(negedge clk);
    valid_i   = v;
    data_i    = b;
    exp_valid = 1'b0;
    exp_error = 1'b0;
    if (v && rst_n) model_byte(b);
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      repeat (gap) step(1'b0, 8'h00);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    logic [AW+DW:0] got;
    #1;
    n_vec++;
    if ({valid_o, error_o, rw_o, addr_o, wdata_o, rdata_o} !==
        {exp_valid, exp_error, exp_rw, exp_addr, exp_wdata, {DW{1'b0}}}) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t got v=%b e=%b rw=%b addr=%h wdata=%h rdata=%h want v=%b e=%b rw=%b addr=%h wdata=%h rdata=0",
               $time, valid_o, error_o, rw_o, addr_o, wdata_o, rdata_o,
               exp_valid, exp_error, exp_rw, exp_addr, exp_wdata);
    end
    if (valid_o === 1'b1) begin
      n_strobe++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected t=%0t got rw=%b addr=%h wdata=%h want no transaction",
                 $time, rw_o, addr_o, wdata_o);
      end else begin
        got = exp_q.pop_front();
        if ({rw_o, addr_o, wdata_o} !== got) begin
          n_err++;
          $display("FAIL sb_txn t=%0t got %h want %h", $time, {rw_o, addr_o, wdata_o}, got);
        end
      end
    end
    if (error_o === 1'b1) n_epulse++;
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    valid_i = 1'b0;
    rst_n   = 1'b0;
    model_clear();
    #1;
    n_vec += 7;
    if (addr_o !== '0)  begin n_err++; $display("FAIL reset_addr got %h want 0", addr_o); end
    if (wdata_o !== '0) begin n_err++; $display("FAIL reset_wdata got %h want 0", wdata_o); end
    if (rdata_o !== '0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    if (rw_o !== 1'b0)  begin n_err++; $display("FAIL reset_rw got %b want 0", rw_o); end
    if (valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", valid_o); end
    if (error_o !== 1'b0) begin n_err++; $display("FAIL reset_error got %b want 0", error_o); end
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0 (IDLE)", dbg_state); end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_read_b2b();
    int s0 = n_strobe;
    int e0 = n_epulse;
    send_str("R1234\015", 0);
    idle(3);
    n_vec += 3;
    if (n_strobe - s0 !== 1) begin n_err++; $display("FAIL read_b2b_strobes got %0d want 1", n_strobe - s0); end
    if (n_epulse - e0 !== 0) begin n_err++; $display("FAIL read_b2b_errors got %0d want 0", n_epulse - e0); end
    if (addr_o !== 16'h1234) begin n_err++; $display("FAIL read_b2b_addr got %h want 1234", addr_o); end
  endtask

  task automatic test_write_gaps();
    int s0 = n_strobe;
    send_str("W00abBEEF\n", 3);
    idle(2);
    n_vec += 3;
    if (n_strobe - s0 !== 1) begin n_err++; $display("FAIL write_gap_strobes got %0d want 1", n_strobe - s0); end
    if (wdata_o !== 16'hBEEF) begin n_err++; $display("FAIL write_gap_wdata got %h want beef", wdata_o); end
    if (rw_o !== 1'b1) begin n_err++; $display("FAIL write_gap_rw got %b want 1", rw_o); end
  endtask

  task automatic test_bad_hex();
    int s0 = n_strobe;
    int e0 = n_epulse;
    send_str("R12G4\015", 0);
    idle(2);
    send_str("R0005\015", 1);
    idle(2);
    n_vec += 3;
    if (n_epulse - e0 !== 1) begin n_err++; $display("FAIL bad_hex_errors got %0d want 1", n_epulse - e0); end
    if (n_strobe - s0 !== 1) begin n_err++; $display("FAIL bad_hex_strobes got %0d want 1", n_strobe - s0); end
    if (addr_o !== 16'h0005) begin n_err++; $display("FAIL bad_hex_addr got %h want 0005", addr_o); end
  endtask

  task automatic test_crlf();
    int s0 = n_strobe;
    int e0 = n_epulse;
    send_str("R1234\015\n", 0);
    send_str("W0001FFFF\015", 0);
    idle(4);
    n_vec += 4;
    if (n_strobe - s0 !== 2) begin n_err++; $display("FAIL crlf_strobes got %0d want 2", n_strobe - s0); end
    if (n_epulse - e0 !== 0) begin n_err++; $display("FAIL crlf_errors got %0d want 0", n_epulse - e0); end
    if (addr_o !== 16'h0001) begin n_err++; $display("FAIL crlf_hold_addr got %h want 0001", addr_o); end
    if (wdata_o !== 16'hFFFF) begin n_err++; $display("FAIL crlf_hold_wdata got %h want ffff", wdata_o); end
  endtask

  task automatic test_eol_err();
    int s0 = n_strobe;
    int e0 = n_epulse;
    send_str("R12345\015", 0);
    idle(1);
    send_str("W12R", 0);
    idle(2);
    n_vec += 3;
    if (n_epulse - e0 !== 2) begin n_err++; $display("FAIL eol_err_errors got %0d want 2", n_epulse - e0); end
    if (n_strobe - s0 !== 0) begin n_err++; $display("FAIL eol_err_strobes got %0d want 0", n_strobe - s0); end
    if (addr_o !== 16'h0001) begin n_err++; $display("FAIL eol_err_hold_addr got %h want 0001", addr_o); end
  endtask

  task automatic test_reset_mid();
    int s0;
    int e0;
    send_str("W0001AB", 0);
    @(negedge clk);
    valid_i = 1'b0;
    rst_n   = 1'b0;
    model_clear();
    #1;
    n_vec += 4;
    if (addr_o !== '0)  begin n_err++; $display("FAIL rstmid_addr got %h want 0", addr_o); end
    if (wdata_o !== '0) begin n_err++; $display("FAIL rstmid_wdata got %h want 0", wdata_o); end
    if (rw_o !== 1'b0)  begin n_err++; $display("FAIL rstmid_rw got %b want 0", rw_o); end
    if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rstmid_state got %0d want 0", dbg_state); end
    idle(2);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = n_strobe;
    e0 = n_epulse;
    send_str("\015", 0);
    idle(3);
    n_vec += 3;
    if (n_strobe - s0 !== 0) begin n_err++; $display("FAIL rstmid_strobes got %0d want 0", n_strobe - s0); end
    if (n_epulse - e0 !== 0) begin n_err++; $display("FAIL rstmid_errors got %0d want 0", n_epulse - e0); end
    if (addr_o !== '0) begin n_err++; $display("FAIL rstmid_after_addr got %h want 0", addr_o); end
  endtask

  function automatic logic [7:0] rand_hex_char();
    int nib = $urandom_range(0, 15);
    if (nib < 10) return 8'(48 + nib);
    return ($urandom_range(0, 1) == 1) ? 8'(65 + nib - 10) : 8'(97 + nib - 10);
  endfunction

  task automatic test_random();
    logic [7:0] fr[$];
    int len;
    for (int f = 0; f < 200; f++) begin
      fr.delete();
      fr.push_back(($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52);
      len = (fr[0] == 8'h57) ? AN + DN : AN;
      for (int i = 0; i < len; i++) fr.push_back(rand_hex_char());
      fr.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
      if ($urandom_range(0, 4) == 0) fr[$urandom_range(1, fr.size() - 1)] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) fr.push_back(8'h0A);
      if ($urandom_range(0, 7) == 0) fr.push_front(8'($urandom_range(0, 255)));
      foreach (fr[i]) begin
        step(1'b1, fr[i]);
        idle($urandom_range(0, 2));
      end
    end
    idle(3);
    n_vec++;
    if (exp_q.size() !== 0) begin n_err++; $display("FAIL random_pending got %0d want 0", exp_q.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_b2b();
    test_write_gaps();
    test_bad_hex();
    test_crlf();
    test_eol_err();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
